dec_a_bin: RTL and testbench

// - Sequential BCD-to-binary converter. Inverse of the binary-to-BCD path that feeds the 7-segment displays.
// - Takes four BCD digits (thousands, hundreds, tens, units) from keypad/switch entry and produces the 16-bit binary

---
 rtl/dec_a_bin_pkg.sv | 17 +
 rtl/dec_a_bin_if.sv | 17 +
 rtl/dec_a_bin_mul10_add.sv | 10 +
 rtl/dec_a_bin.sv | 100 ++++++++++
 tb/tb_dec_a_bin.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/dec_a_bin_pkg.sv
// Shared types and constants for the BCD-to-binary converter.
package dec_a_bin_pkg;
  localparam int DIGITS = 4;
  localparam int WIDTH  = 16;
  localparam int BCD_W  = 4;
  localparam int CNT_W  = $clog2(DIGITS);
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_ACC  = 1'b1
  } state_t;

  function automatic logic bcd_ok(input logic [BCD_W-1:0] d);
    return d <= BCD_MAX;
  endfunction
endpackage

// File: rtl/dec_a_bin_if.sv
// Request digits / result handshake between the entry logic and the converter.
interface dec_a_bin_if;
  import dec_a_bin_pkg::*;

  logic             start;
  logic [BCD_W-1:0] um;
  logic [BCD_W-1:0] cen;
  logic [BCD_W-1:0] dec;
  logic [BCD_W-1:0] un;
  logic [WIDTH-1:0] bin;
  logic             busy;
  logic             done;
  logic             err;

  modport master (output start, um, cen, dec, un, input bin, busy, done, err);
  modport slave  (input start, um, cen, dec, un, output bin, busy, done, err);
endinterface

// File: rtl/dec_a_bin_mul10_add.sv
// Combinational y = a*10 + d, built from two shifts so no multiplier is inferred.
module mul10_add #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [3:0]       i_d,
  output logic [WIDTH-1:0] o_y
);
  assign o_y = (i_a << 3) + (i_a << 1) + WIDTH'(i_d);
endmodule

// File: rtl/dec_a_bin.sv
// Sequential BCD-to-binary converter: one digit per clock, MS digit first,
// result and a one-cycle done pulse DIGITS edges after start is accepted.
module dec_a_bin
  import dec_a_bin_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  dec_a_bin_if.slave  bus
);
  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [DIGITS*BCD_W-1:0] r_sr;
  logic [WIDTH-1:0]        r_acc;
  logic [WIDTH-1:0]        r_bin;
  logic [WIDTH-1:0]        w_acc_nxt;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_err;
  logic                    w_digits_ok;
  logic                    w_accept;
  logic                    w_reject;
  logic                    w_last;

  assign w_digits_ok = bcd_ok(bus.um) & bcd_ok(bus.cen) & bcd_ok(bus.dec) & bcd_ok(bus.un);

  mul10_add #(.WIDTH(WIDTH)) u_mul10 (
    .i_a (r_acc),
    .i_d (r_sr[DIGITS*BCD_W-1 -: BCD_W]),
    .o_y (w_acc_nxt)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_reject    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          if (w_digits_ok) begin
            w_accept    = 1'b1;
            w_state_nxt = S_ACC;
          end else begin
            w_reject = 1'b1;
          end
        end
      end
      S_ACC: begin
        if (r_cnt == CNT_W'(DIGITS - 1)) begin
          w_last      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Inputs are only looked at on the accept edge; the shift register feeds the datapath after that.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sr   <= '0;
      r_acc  <= '0;
      r_bin  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_done <= w_last | w_reject;
      if (w_accept) begin
        r_sr   <= {bus.um, bus.cen, bus.dec, bus.un};
        r_acc  <= '0;
        r_cnt  <= '0;
        r_busy <= 1'b1;
        r_err  <= 1'b0;
      end
      if (w_reject) r_err <= 1'b1;
      if (r_state == S_ACC) begin
        r_acc <= w_acc_nxt;
        r_sr  <= r_sr << BCD_W;
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_last) begin
        r_bin  <= w_acc_nxt;
        r_busy <= 1'b0;
      end
    end
  end

  assign bus.bin  = r_bin;
  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.err  = r_err;
endmodule

// File: tb/tb_dec_a_bin.sv
// Directed and random checks of dec_a_bin against a decimal-arithmetic reference.
module tb_dec_a_bin;
  logic clk = 1'b0;
  logic rst;
  dec_a_bin_if bus();

  dec_a_bin dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] m_bin = '0;
  logic        m_err = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_digits(input logic [3:0] a, b, c, d);
    bus.um  = a;
    bus.cen = b;
    bus.dec = c;
    bus.un  = d;
  endtask

  // One full request, checked cycle by cycle; returns one cycle after done.
  task automatic conv(input logic [3:0] a, b, c, d);
    bit ok;
    int val;
    ok  = (a <= 9) && (b <= 9) && (c <= 9) && (d <= 9);
    val = int'(a) * 1000 + int'(b) * 100 + int'(c) * 10 + int'(d);
    set_digits(a, b, c, d);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    if (ok) begin
      for (int k = 0; k < 4; k++) begin
        chk("busy_run", bus.busy, 1);
        chk("done_early", bus.done, 0);
        chk("err_clr", bus.err, 0);
        chk("bin_hold", bus.bin, m_bin);
        step();
      end
      chk("done_pulse", bus.done, 1);
      chk("busy_end", bus.busy, 0);
      chk("err_ok", bus.err, 0);
      chk("bin_val", bus.bin, val);
      m_bin = 16'(val);
      m_err = 1'b0;
    end else begin
      chk("done_errpulse", bus.done, 1);
      chk("err_set", bus.err, 1);
      chk("busy_err", bus.busy, 0);
      chk("bin_keep", bus.bin, m_bin);
      m_err = 1'b1;
    end
    step();
    chk("done_off", bus.done, 0);
    chk("busy_off", bus.busy, 0);
    chk("err_sticky", bus.err, m_err);
    chk("bin_after", bus.bin, m_bin);
  endtask

  initial begin
    logic [3:0] dg [4];
    bus.start = 1'b0;
    set_digits(0, 0, 0, 0);
    rst = 1'b1;
    step();
    step();
    chk("rst_bin", bus.bin, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err, 0);
    rst = 1'b0;
    step();

    conv(1, 2, 3, 4);
    conv(9, 9, 9, 9);
    conv(0, 0, 0, 0);
    conv(1, 2, 3, 4);
    conv(1, 4'hA, 3, 4);
    conv(1, 2, 3, 4);

    // start while busy is ignored
    set_digits(5, 6, 7, 8);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int idx = 0; idx < 8; idx++) begin
      if (idx == 1) begin
        set_digits(1, 1, 1, 1);
        bus.start = 1'b1;
      end
      if (idx == 2) bus.start = 1'b0;
      chk("ign_done", bus.done, (idx == 4));
      if (idx >= 4) chk("ign_bin", bus.bin, 16'h162E);
      step();
    end
    m_bin = 16'h162E;

    // reset mid-conversion
    set_digits(4, 3, 2, 1);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    step();
    rst = 1'b1;
    #1;
    chk("mid_rst_bin", bus.bin, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_done", bus.done, 0);
    chk("mid_rst_err", bus.err, 0);
    m_bin = '0;
    m_err = 1'b0;
    step();
    rst = 1'b0;
    for (int idx = 0; idx < 6; idx++) begin
      step();
      chk("post_rst_done", bus.done, 0);
      chk("post_rst_bin", bus.bin, 0);
    end

    // start held high: one result every five cycles
    set_digits(0, 0, 4, 2);
    bus.start = 1'b1;
    step();
    for (int idx = 0; idx < 15; idx++) begin
      chk("held_done", bus.done, (idx % 5 == 4));
      chk("held_busy", bus.busy, (idx % 5 != 4));
      if (idx >= 4) chk("held_bin", bus.bin, 16'h002A);
      step();
    end
    bus.start = 1'b0;
    for (int idx = 0; idx < 6; idx++) step();
    m_bin = 16'h002A;
    chk("held_final", bus.bin, m_bin);

    // random requests, about one in five carrying a non-BCD digit
    for (int n = 0; n < 40; n++) begin
      for (int j = 0; j < 4; j++) dg[j] = 4'($urandom_range(0, 9));
      if ($urandom_range(0, 4) == 0) dg[$urandom_range(0, 3)] = 4'($urandom_range(10, 15));
      conv(dg[0], dg[1], dg[2], dg[3]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
